// File: rtl/tr_pulse_ramp.sv
// tr_pulse_ramp
// Multi-channel stepper pulse generator. Each channel converts a target step
// period (counted in d_v ticks) into a fixed-width step pulse train, keeps a
// signed position count and only reverses direction while the axis is stopped.
//
// Optional feature macro: TR_PULSE_RAMP_EN
//   defined   : the period slews by RAMP_STEP per step between N_START and the
//               target; stopping and reversing decelerate to N_START first.
//   undefined : the period jumps straight to the target; stop and reversal
//               take effect at the next step.
//
// Ports
//   clk         system clock (50 MHz)
//   rst         synchronous reset, active-low
//   d_v         timebase tick strobe, one clk wide
//   drv_en_SM   per-channel enable
//   drv_dir_in  per-channel requested direction (1 = forward)
//   n           per-channel target period, unsigned, 0 = stop
//   drv_step    per-channel step pulse, PULSE_W clk high
//   drv_dir     per-channel applied direction
//   step_cnt    per-channel signed position, wraps two's complement
//   busy        per-channel "not idle" flag
module tr_pulse_ramp #(
    parameter int CH        = 2,
    parameter int PERIOD_W  = 17,
    parameter int CNT_W     = 32,
    parameter int N_START   = 100,
    parameter int N_MIN     = 10,
    parameter int RAMP_STEP = 10,
    parameter int PULSE_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   d_v,
    input  logic [CH-1:0]          drv_en_SM,
    input  logic [CH-1:0]          drv_dir_in,
    input  logic [CH*PERIOD_W-1:0] n,
    output logic [CH-1:0]          drv_step,
    output logic [CH-1:0]          drv_dir,
    output logic [CH*CNT_W-1:0]    step_cnt,
    output logic [CH-1:0]          busy
);

    // Period arithmetic is done one bit wider so that additions saturate
    // instead of wrapping.
    localparam int EXT_W = PERIOD_W + 1;
    localparam logic [EXT_W-1:0]    START_X = EXT_W'(N_START);
    localparam logic [EXT_W-1:0]    MIN_X   = EXT_W'(N_MIN);
    localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(N_START);
    localparam int PT_W = $clog2(PULSE_W + 1);
    localparam logic [PT_W-1:0]     PULSE_X = PT_W'(PULSE_W);

`ifdef TR_PULSE_RAMP_EN
    typedef enum logic [1:0] {IDLE, RUN, STOP, REV} state_t;
    localparam logic [EXT_W-1:0]    STEP_X  = EXT_W'(RAMP_STEP);

    function automatic logic [EXT_W-1:0] sat_add(input logic [EXT_W-1:0] a,
                                                 input logic [EXT_W-1:0] b);
        logic [EXT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[EXT_W] ? '1 : s[EXT_W-1:0];
    endfunction

    function automatic logic [EXT_W-1:0] sat_sub(input logic [EXT_W-1:0] a,
                                                 input logic [EXT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    // One ramp step of the current period toward t, never overshooting t.
    // The result never exceeds max(c, t), so it fits back into PERIOD_W.
    function automatic logic [PERIOD_W-1:0] ramp(input logic [PERIOD_W-1:0] c_in,
                                                 input logic [EXT_W-1:0]    t);
        logic [EXT_W-1:0] c;
        logic [EXT_W-1:0] r;
        c = {1'b0, c_in};
        if (c > t) begin
            r = sat_sub(c, STEP_X);
            if (r < t) r = t;
        end else begin
            r = sat_add(c, STEP_X);
            if (r > t) r = t;
        end
        return PERIOD_W'(r);
    endfunction
`else
    typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

    // Clamp a nonzero request into [N_MIN, N_START]; 0 maps to N_START.
    function automatic logic [EXT_W-1:0] clamp_tgt(input logic [PERIOD_W-1:0] n_in);
        logic [EXT_W-1:0] v;
        v = {1'b0, n_in};
        if (v == '0)          return START_X;
        else if (v < MIN_X)   return MIN_X;
        else if (v > START_X) return START_X;
        else                  return v;
    endfunction

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t              state, state_nx;
        logic [PERIOD_W-1:0] cnt, cnt_nx;
        logic [PERIOD_W-1:0] cur, cur_nx;
        logic [PT_W-1:0]     ptmr, ptmr_nx;
        logic [CNT_W-1:0]    pos, pos_nx;
        logic                dir, dir_nx;
        logic                busy_q, busy_nx;
        logic [PERIOD_W-1:0] n_ch;
        logic [EXT_W-1:0]    tgt;
        logic                stop_req, rev_req, step_ev;

        assign n_ch     = n[g*PERIOD_W +: PERIOD_W];
        assign tgt      = clamp_tgt(n_ch);
        assign stop_req = (n_ch == '0);
        assign rev_req  = (drv_dir_in[g] != dir);
        assign step_ev  = d_v && (state != IDLE) && (cnt == cur - PERIOD_W'(1));

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            cur_nx   = cur;
            ptmr_nx  = (ptmr != '0) ? ptmr - PT_W'(1) : '0;
            pos_nx   = pos;
            dir_nx   = dir;

            if (!drv_en_SM[g]) begin
                // Disable kills the pulse at once but keeps the position.
                state_nx = IDLE;
                cnt_nx   = '0;
                cur_nx   = START_P;
                ptmr_nx  = '0;
            end else if (state == IDLE) begin
                cnt_nx = '0;
                cur_nx = START_P;
                if (!stop_req) begin
                    // Direction is only ever changed while stopped.
                    dir_nx   = drv_dir_in[g];
                    state_nx = RUN;
`ifndef TR_PULSE_RAMP_EN
                    cur_nx   = PERIOD_W'(tgt);
`endif
                end
            end else begin
                if (d_v) cnt_nx = step_ev ? '0 : cnt + PERIOD_W'(1);
                if (step_ev) begin
                    // A step during a live pulse reloads the timer; pulses merge.
                    ptmr_nx = PULSE_X;
                    pos_nx  = dir ? pos + CNT_W'(1) : pos - CNT_W'(1);
                end
`ifdef TR_PULSE_RAMP_EN
                case (state)
                    RUN: begin
                        if (step_ev) begin
                            // Stop and reversal both decelerate toward N_START.
                            cur_nx = ramp(cur, (stop_req || rev_req) ? START_X : tgt);
                            if (stop_req)     state_nx = STOP;
                            else if (rev_req) state_nx = REV;
                        end
                    end
                    STOP: begin
                        if (step_ev) begin
                            if (cur == START_P && stop_req) state_nx = IDLE;
                            else                            cur_nx   = ramp(cur, START_X);
                        end
                        if (!stop_req) state_nx = RUN;
                    end
                    REV: begin
                        if (step_ev) begin
                            if (cur == START_P) begin
                                state_nx = IDLE;
                                dir_nx   = drv_dir_in[g];
                            end else begin
                                cur_nx = ramp(cur, START_X);
                            end
                        end
                    end
                    default: state_nx = IDLE;
                endcase
`else
                if (step_ev) begin
                    if (stop_req || rev_req) begin
                        state_nx = IDLE;
                        cur_nx   = START_P;
                        if (rev_req) dir_nx = drv_dir_in[g];
                    end else begin
                        cur_nx = PERIOD_W'(tgt);
                    end
                end
`endif
            end
            busy_nx = (state_nx != IDLE);
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                state  <= IDLE;
                cnt    <= '0;
                cur    <= START_P;
                ptmr   <= '0;
                pos    <= '0;
                dir    <= 1'b1;
                busy_q <= 1'b0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                cur    <= cur_nx;
                ptmr   <= ptmr_nx;
                pos    <= pos_nx;
                dir    <= dir_nx;
                busy_q <= busy_nx;
            end
        end

        assign drv_step[g]                = (ptmr != '0);
        assign drv_dir[g]                 = dir;
        assign busy[g]                    = busy_q;
        assign step_cnt[g*CNT_W +: CNT_W] = pos;
    end

endmodule

// File: tb/tb_tr_pulse_ramp.sv
// Bench for tr_pulse_ramp (default parameters, d_v every 5 clk). Channel 0 is
// driven through a table of {inputs, expected step interval/position/direction/
// busy}; each row is applied and then the next step of channel 0 is checked.
// Hand sequences cover reset state, idle silence, disable mid-pulse, channel
// independence and reset mid-pulse. Expected tables follow TR_PULSE_RAMP_EN.
module tb_tr_pulse_ramp;

    localparam int PW = 17;
    localparam int CW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           d_v;
    logic [1:0]     en;
    logic [1:0]     dir_in;
    logic [PW-1:0]  n_ch [2];
    logic [2*PW-1:0] n;
    logic [1:0]     drv_step;
    logic [1:0]     drv_dir;
    logic [2*CW-1:0] step_cnt;
    logic [1:0]     busy;

    assign n = {n_ch[1], n_ch[0]};

    tr_pulse_ramp dut (
        .clk        (clk),
        .rst        (rst),
        .d_v        (d_v),
        .drv_en_SM  (en),
        .drv_dir_in (dir_in),
        .n          (n),
        .drv_step   (drv_step),
        .drv_dir    (drv_dir),
        .step_cnt   (step_cnt),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // d_v: one clk high every 5 clk, changed on the falling edge.
    int dv_ctr = 0;
    initial begin
        d_v = 1'b0;
        forever begin
            @(negedge clk);
            dv_ctr = (dv_ctr == 4) ? 0 : dv_ctr + 1;
            d_v = (dv_ctr == 0);
        end
    end

    // Step monitor: d_v ticks between rising edges of drv_step per channel.
    int   ticks  [2] = '{0, 0};
    int   nsteps [2] = '{0, 0};
    int   ivl    [2] = '{0, 0};
    logic prev_step [2] = '{1'b0, 1'b0};
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (d_v) ticks[c]++;
                if (drv_step[c] && !prev_step[c]) begin
                    ivl[c]   = ticks[c];
                    ticks[c] = 0;
                    nsteps[c]++;
                end
                prev_step[c] = drv_step[c];
            end
        end
    end

    function automatic int pos_of(input int c);
        logic [CW-1:0] v;
        v = step_cnt[c*CW +: CW];
        return int'($signed(v));
    endfunction

    task automatic wait_step(input int c, input int bound, output bit ok);
        int s;
        s  = nsteps[c];
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #2;
            if (nsteps[c] != s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Align to a falling edge where the coming rising edge has no d_v.
    task automatic sync_dv_low();
        @(negedge clk);
        #1;
        while (d_v) begin
            @(negedge clk);
            #1;
        end
    endtask

    typedef struct {
        bit restart;
        int nval;
        bit dir;
        int ivl;
        int cnt;
        bit dir_after;
        bit busy_after;
    } vec_t;

    vec_t tbl[$];
    int   seg1_last;

    function automatic vec_t mk(bit r, int nv, bit d, int iv, int ct, bit da, bit ba);
        vec_t v;
        v.restart = r; v.nval = nv; v.dir = d; v.ivl = iv;
        v.cnt = ct; v.dir_after = da; v.busy_after = ba;
        return v;
    endfunction

    task automatic run_vecs(input int first, input int last);
        bit ok;
        int w;
        for (int i = first; i <= last; i++) begin
            if (tbl[i].restart) begin
                sync_dv_low();
                ticks[0] = 0;
            end
            n_ch[0]   = PW'(tbl[i].nval);
            dir_in[0] = tbl[i].dir;
            wait_step(0, 1000, ok);
            check($sformatf("v%0d step seen", i), ok, 1);
            if (ok) begin
                check($sformatf("v%0d interval", i), ivl[0], tbl[i].ivl);
                check($sformatf("v%0d step_cnt", i), pos_of(0), tbl[i].cnt);
                check($sformatf("v%0d drv_dir", i), drv_dir[0], tbl[i].dir_after);
                check($sformatf("v%0d busy", i), busy[0], tbl[i].busy_after);
                w = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!drv_step[0]) break;
                    w++;
                    @(posedge clk);
                    #2;
                end
                check($sformatf("v%0d pulse width", i), w, 2);
            end
        end
    endtask

`ifdef TR_PULSE_RAMP_EN
    localparam int REEN_IVL = 100;
`else
    localparam int REEN_IVL = 50;
`endif

    initial begin
        bit ok;
        int sc0, ns0;

`ifdef TR_PULSE_RAMP_EN
        // Accelerate to 50, stop with deceleration to IDLE.
        tbl.push_back(mk(1, 50, 1, 100,  1, 1, 1));
        tbl.push_back(mk(0, 50, 1,  90,  2, 1, 1));
        tbl.push_back(mk(0, 50, 1,  80,  3, 1, 1));
        tbl.push_back(mk(0, 50, 1,  70,  4, 1, 1));
        tbl.push_back(mk(0, 50, 1,  60,  5, 1, 1));
        tbl.push_back(mk(0, 50, 1,  50,  6, 1, 1));
        tbl.push_back(mk(0, 50, 1,  50,  7, 1, 1));
        tbl.push_back(mk(0,  0, 1,  50,  8, 1, 1));
        tbl.push_back(mk(0,  0, 1,  60,  9, 1, 1));
        tbl.push_back(mk(0,  0, 1,  70, 10, 1, 1));
        tbl.push_back(mk(0,  0, 1,  80, 11, 1, 1));
        tbl.push_back(mk(0,  0, 1,  90, 12, 1, 1));
        tbl.push_back(mk(0,  0, 1, 100, 13, 1, 0));
        seg1_last = 12;
        // Restart, then reverse: decel to 100, flip in IDLE, re-accelerate.
        tbl.push_back(mk(1, 50, 1, 100, 14, 1, 1));
        tbl.push_back(mk(0, 50, 1,  90, 15, 1, 1));
        tbl.push_back(mk(0, 50, 1,  80, 16, 1, 1));
        tbl.push_back(mk(0, 50, 1,  70, 17, 1, 1));
        tbl.push_back(mk(0, 50, 1,  60, 18, 1, 1));
        tbl.push_back(mk(0, 50, 0,  50, 19, 1, 1));
        tbl.push_back(mk(0, 50, 0,  60, 20, 1, 1));
        tbl.push_back(mk(0, 50, 0,  70, 21, 1, 1));
        tbl.push_back(mk(0, 50, 0,  80, 22, 1, 1));
        tbl.push_back(mk(0, 50, 0,  90, 23, 1, 1));
        tbl.push_back(mk(0, 50, 0, 100, 24, 0, 0));
        tbl.push_back(mk(0, 50, 0, 100, 23, 0, 1));
        tbl.push_back(mk(0, 50, 0,  90, 22, 0, 1));
        tbl.push_back(mk(0, 50, 0,  80, 21, 0, 1));
`else
        // Direct period loading, clamping of 3 and 500, stop at next step.
        tbl.push_back(mk(1,  50, 1,  50,  1, 1, 1));
        tbl.push_back(mk(0,  50, 1,  50,  2, 1, 1));
        tbl.push_back(mk(0,  20, 1,  50,  3, 1, 1));
        tbl.push_back(mk(0,  20, 1,  20,  4, 1, 1));
        tbl.push_back(mk(0,   3, 1,  20,  5, 1, 1));
        tbl.push_back(mk(0,   3, 1,  10,  6, 1, 1));
        tbl.push_back(mk(0, 500, 1,  10,  7, 1, 1));
        tbl.push_back(mk(0, 500, 1, 100,  8, 1, 1));
        tbl.push_back(mk(0,  50, 1, 100,  9, 1, 1));
        tbl.push_back(mk(0,   0, 1,  50, 10, 1, 0));
        seg1_last = 9;
        // Restart reversed, then reverse again mid-run.
        tbl.push_back(mk(1,  50, 0,  50,  9, 0, 1));
        tbl.push_back(mk(0,  50, 0,  50,  8, 0, 1));
        tbl.push_back(mk(0,  50, 1,  50,  7, 1, 0));
        tbl.push_back(mk(0,  50, 1,  50,  8, 1, 1));
        tbl.push_back(mk(0,  50, 1,  50,  9, 1, 1));
`endif

        rst     = 1'b0;
        en      = 2'b00;
        dir_in  = 2'b11;
        n_ch[0] = '0;
        n_ch[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset drv_step", drv_step, 0);
        check("reset drv_dir", drv_dir, 3);
        check("reset step_cnt", step_cnt, 0);
        check("reset busy", busy, 0);

        @(negedge clk);
        rst = 1'b1;
        en  = 2'b01;
        repeat (4) @(posedge clk);
        #1;
        check("enabled n=0 stays idle", busy[0], 0);

        run_vecs(0, seg1_last);

        // Stopped channel stays silent with its position held.
        ns0 = nsteps[0];
        sc0 = pos_of(0);
        repeat (750) @(posedge clk);
        #2;
        check("idle no steps", nsteps[0] - ns0, 0);
        check("idle busy", busy[0], 0);
        check("idle step_cnt held", pos_of(0), sc0);

        run_vecs(seg1_last + 1, tbl.size() - 1);

        check("ch1 untouched step_cnt", pos_of(1), 0);
        check("ch1 untouched busy", busy[1], 0);

        // Start ch1, then drop ch0 enable in the middle of a ch0 pulse.
        sync_dv_low();
        ticks[1]  = 0;
        n_ch[1]   = PW'(100);
        dir_in[1] = 1'b1;
        en[1]     = 1'b1;
        wait_step(0, 1000, ok);
        check("ch0 step before disable", ok, 1);
        sc0 = pos_of(0);
        @(negedge clk);
        en[0] = 1'b0;
        @(posedge clk);
        #1;
        check("disable drv_step low", drv_step[0], 0);
        check("disable busy low", busy[0], 0);
        check("disable step_cnt held", pos_of(0), sc0);
        check("ch1 busy while ch0 off", busy[1], 1);

        wait_step(1, 1000, ok);
        check("ch1 step seen", ok, 1);
        check("ch1 interval", ivl[1], 100);
        check("ch1 step_cnt", pos_of(1), 1);
        check("ch0 held during ch1 run", pos_of(0), sc0);

        // Re-enable ch0 reversed, then reset in the middle of its pulse.
        sync_dv_low();
        ticks[0]  = 0;
        dir_in[0] = 1'b0;
        en[0]     = 1'b1;
        wait_step(0, 1000, ok);
        check("ch0 re-enable step seen", ok, 1);
        check("ch0 re-enable interval", ivl[0], REEN_IVL);
        check("ch0 re-enable step_cnt", pos_of(0), sc0 - 1);
        check("ch0 re-enable drv_dir", drv_dir[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid-run reset drv_step", drv_step, 0);
        check("mid-run reset drv_dir", drv_dir, 3);
        check("mid-run reset step_cnt", step_cnt, 0);
        check("mid-run reset busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        en  = 2'b00;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
